btn_debounce_repeat: RTL and testbench

//  Consumes the 100 Hz square wave from clk_div_to_100 and uses it as a sample

---
 rtl/btn_pkg.sv | 29 ++
 rtl/btn_lane.sv | 119 +++++++++++
 rtl/btn_debounce_repeat.sv | 65 ++++++
 tb/tb_btn_debounce_repeat.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module : btn_pkg
//  Brief  : Shared lane indices, repeat FSM encodings and helpers for the
//           push-button debounce/repeat block.
//  Rev    : 1.0  initial release
// ============================================================================
package btn_pkg;

   localparam int N_BTN_DEF = 5;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_SEL   = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_WAIT = 2'd1,
      REPEAT    = 2'd2
   } rpt_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_lane.sv
`default_nettype none
// ============================================================================
//  Module : btn_lane
//  Brief  : One button lane: 2-FF synchronizer, tick-sampled debounce counter
//           and hold-to-repeat FSM producing a registered press pulse.
//  Rev    : 1.0  initial release
// ============================================================================
module btn_lane
   import btn_pkg::*;
#(
   parameter int STABLE_TICKS = 3,
   parameter int REPEAT_DELAY = 40,
   parameter int REPEAT_RATE  = 10
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int c_dcnt_w = $clog2(STABLE_TICKS + 1);
   localparam int c_rcnt_w = max_int(1, $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1));
   localparam logic [c_dcnt_w-1:0] c_dcnt_last  = c_dcnt_w'(STABLE_TICKS - 1);
   localparam logic [c_rcnt_w-1:0] c_delay_last = c_rcnt_w'(REPEAT_DELAY - 1);
   localparam logic [c_rcnt_w-1:0] c_rate_last  = c_rcnt_w'(REPEAT_RATE - 1);
   localparam bit                  c_repeat_on  = (REPEAT_RATE != 0);

   logic                r_meta;
   logic                r_sync;
   logic [c_dcnt_w-1:0] r_dcnt;
   logic                r_level;
   logic                r_level_d;
   logic                r_press;
   logic [c_rcnt_w-1:0] r_rcnt;
   rpt_state_t          r_state;

   // The level flips on the tick that completes the run of agreeing samples.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_dcnt  <= '0;
         r_level <= 1'b0;
      end else begin
         r_meta <= raw;
         r_sync <= r_meta;
         if (tick) begin
            if (r_sync != r_level) begin
               if (r_dcnt == c_dcnt_last) begin
                  r_level <= r_sync;
                  r_dcnt  <= '0;
               end else begin
                  r_dcnt <= r_dcnt + 1'b1;
               end
            end else begin
               r_dcnt <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rcnt    <= '0;
         r_press   <= 1'b0;
         r_level_d <= 1'b0;
      end else begin
         r_level_d <= r_level;
         r_press   <= 1'b0;
         if (!r_level) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (!r_level_d) begin
                     r_press <= 1'b1;
                     r_rcnt  <= '0;
                     if (c_repeat_on) r_state <= HOLD_WAIT;
                  end
               end
               HOLD_WAIT: begin
                  if (tick) begin
                     if (r_rcnt == c_delay_last) begin
                        r_press <= 1'b1;
                        r_rcnt  <= '0;
                        r_state <= REPEAT;
                     end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                     end
                  end
               end
               REPEAT: begin
                  if (tick) begin
                     if (r_rcnt == c_rate_last) begin
                        r_press <= 1'b1;
                        r_rcnt  <= '0;
                     end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_rcnt  <= '0;
               end
            endcase
         end
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/btn_debounce_repeat.sv
`default_nettype none
// ============================================================================
//  Module : btn_debounce_repeat
//  Brief  : Turns the 100 Hz divider output into a one-cycle sample tick and
//           debounces N_BTN buttons with optional hold-to-repeat press pulses.
//  Rev    : 1.0  initial release
// ============================================================================
module btn_debounce_repeat
   import btn_pkg::*;
#(
   parameter int N_BTN        = N_BTN_DEF,
   parameter int STABLE_TICKS = 3,
   parameter int REPEAT_DELAY = 40,
   parameter int REPEAT_RATE  = 10
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             slow_clk,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic             tick
);

   logic r_slow_meta;
   logic r_slow_sync;
   logic r_slow_prev;
   logic r_tick;

   // slow_clk is sampled as data; only its rising edge matters.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_slow_meta <= 1'b0;
         r_slow_sync <= 1'b0;
         r_slow_prev <= 1'b0;
         r_tick      <= 1'b0;
      end else begin
         r_slow_meta <= slow_clk;
         r_slow_sync <= r_slow_meta;
         r_slow_prev <= r_slow_sync;
         r_tick      <= r_slow_sync & ~r_slow_prev;
      end
   end

   assign tick = r_tick;

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_lane
         btn_lane #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
         ) u_lane (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .tick   (r_tick),
            .raw    (btn_raw[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_repeat.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : tb_btn_debounce_repeat
//  Brief  : Directed self-checking bench; dut_a has repeat disabled, dut_b
//           uses a short repeat delay/rate. Tick every 10 clk_in cycles.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_btn_debounce_repeat;

   localparam int N = 5;

   logic         clk_in   = 1'b0;
   logic         rst_n    = 1'b0;
   logic         slow_clk = 1'b0;
   logic         slow_run = 1'b1;
   logic [N-1:0] raw_a    = '0;
   logic [N-1:0] raw_b    = '0;
   logic [N-1:0] level_a, press_a, level_b, press_b;
   logic         tick_a, tick_b;

   int checks = 0;
   int errors = 0;
   int press_cnt_a [N] = '{default: 0};
   int press_cnt_b [N] = '{default: 0};

   btn_debounce_repeat #(
      .N_BTN(N), .STABLE_TICKS(3), .REPEAT_DELAY(40), .REPEAT_RATE(0)
   ) dut_a (
      .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .btn_raw(raw_a),
      .btn_level(level_a), .btn_press(press_a), .tick(tick_a)
   );

   btn_debounce_repeat #(
      .N_BTN(N), .STABLE_TICKS(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
   ) dut_b (
      .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .btn_raw(raw_b),
      .btn_level(level_b), .btn_press(press_b), .tick(tick_b)
   );

   always #5 clk_in = ~clk_in;

   // Toggles every 5 clk_in cycles, offset away from the clk_in edges.
   initial begin
      #3;
      forever begin
         #50;
         if (slow_run) slow_clk = ~slow_clk;
      end
   end

   always @(negedge clk_in) begin
      for (int i = 0; i < N; i++) begin
         if (press_a[i] === 1'b1) press_cnt_a[i]++;
         if (press_b[i] === 1'b1) press_cnt_b[i]++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (tick_a !== 1'b1 && n < 40);
      if (tick_a !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_tick: tick=%b after 40 cycles, required 1", tick_a);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      raw_a = '0;
      raw_b = '0;
      repeat (4) @(negedge clk_in);
      checks++;
      if ({level_a, press_a, tick_a} !== 11'b0) begin
         errors++;
         $display("FAIL reset_a: level=%b press=%b tick=%b required all 0", level_a, press_a, tick_a);
      end
      checks++;
      if ({level_b, press_b, tick_b} !== 11'b0) begin
         errors++;
         $display("FAIL reset_b: level=%b press=%b tick=%b required all 0", level_b, press_b, tick_b);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk_in);
      checks++;
      if ({level_a, press_a, level_b, press_b} !== 20'b0) begin
         errors++;
         $display("FAIL reset_release: level_a=%b level_b=%b required 0", level_a, level_b);
      end
   endtask

   task automatic test_tick();
      int n;
      logic seen_low;
      wait_tick();
      n = 0;
      seen_low = 1'b0;
      do begin
         @(negedge clk_in);
         n++;
         if (n == 1) seen_low = ~tick_a;
      end while (tick_a !== 1'b1 && n < 40);
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL tick_period: %0d cycles, required 10", n);
      end
      checks++;
      if (seen_low !== 1'b1) begin
         errors++;
         $display("FAIL tick_width: tick still high one cycle later, required one-cycle pulse");
      end
      checks++;
      if (tick_b !== tick_a) begin
         errors++;
         $display("FAIL tick_match: tick_b=%b required %b", tick_b, tick_a);
      end
   endtask

   task automatic test_clean_press();
      int snap;
      logic e;
      wait_tick();
      snap = press_cnt_a[0];
      raw_a[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_tick();
         @(negedge clk_in);
         e = (k == 3);
         checks++;
         if (level_a[0] !== e) begin
            errors++;
            $display("FAIL clean_rise tick %0d: level=%b required %b", k, level_a[0], e);
         end
      end
      @(negedge clk_in);
      checks++;
      if (press_a !== 5'b00001) begin
         errors++;
         $display("FAIL clean_press_pulse: press=%b required 00001", press_a);
      end
      @(negedge clk_in);
      checks++;
      if (press_a !== 5'b00000) begin
         errors++;
         $display("FAIL clean_press_width: press=%b required 00000", press_a);
      end
      repeat (7) wait_tick();
      checks++;
      if (press_cnt_a[0] - snap != 1) begin
         errors++;
         $display("FAIL clean_press_count: %0d pulses, required 1", press_cnt_a[0] - snap);
      end
      raw_a[0] = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         wait_tick();
         @(negedge clk_in);
         e = (k < 3);
         checks++;
         if (level_a[0] !== e) begin
            errors++;
            $display("FAIL clean_fall tick %0d: level=%b required %b", k, level_a[0], e);
         end
      end
      repeat (3) @(negedge clk_in);
      checks++;
      if (press_cnt_a[0] - snap != 1) begin
         errors++;
         $display("FAIL clean_release_pulse: %0d pulses, required 1", press_cnt_a[0] - snap);
      end
   endtask

   task automatic test_bounce();
      int   snap;
      logic seq [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic e;
      wait_tick();
      snap = press_cnt_a[0];
      for (int k = 0; k < 7; k++) begin
         raw_a[0] = seq[k];
         wait_tick();
         @(negedge clk_in);
         e = (k == 6);
         checks++;
         if (level_a[0] !== e) begin
            errors++;
            $display("FAIL bounce tick %0d: level=%b required %b", k + 1, level_a[0], e);
         end
      end
      repeat (3) wait_tick();
      checks++;
      if (press_cnt_a[0] - snap != 1) begin
         errors++;
         $display("FAIL bounce_count: %0d pulses, required 1", press_cnt_a[0] - snap);
      end
      raw_a[0] = 1'b0;
      repeat (4) wait_tick();
      @(negedge clk_in);
      checks++;
      if (level_a[0] !== 1'b0) begin
         errors++;
         $display("FAIL bounce_release: level=%b required 0", level_a[0]);
      end
   endtask

   task automatic test_glitch();
      int snap;
      wait_tick();
      snap = press_cnt_a[0];
      raw_a[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         wait_tick();
         if (k == 2) raw_a[0] = 1'b0;
         @(negedge clk_in);
         checks++;
         if (level_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch tick %0d: level=%b required 0", k, level_a[0]);
         end
      end
      checks++;
      if (press_cnt_a[0] - snap != 0) begin
         errors++;
         $display("FAIL glitch_count: %0d pulses, required 0", press_cnt_a[0] - snap);
      end
   endtask

   task automatic test_repeat();
      int          snap;
      logic [15:0] exp_mask;
      logic        seen;
      logic        e;
      exp_mask = 16'h1551;
      wait_tick();
      snap = press_cnt_b[0];
      raw_b[0] = 1'b1;
      repeat (3) wait_tick();
      for (int idx = 0; idx < 16; idx++) begin
         if (idx > 0) wait_tick();
         seen = 1'b0;
         repeat (3) begin
            @(negedge clk_in);
            seen = seen | press_b[0];
         end
         e = exp_mask[idx];
         checks++;
         if (seen !== e) begin
            errors++;
            $display("FAIL repeat tick %0d: pulse=%b required %b", idx, seen, e);
         end
         if (idx == 10) raw_b[0] = 1'b0;
         if (idx == 12 || idx == 13) begin
            e = (idx == 12);
            checks++;
            if (level_b[0] !== e) begin
               errors++;
               $display("FAIL repeat_level tick %0d: level=%b required %b", idx, level_b[0], e);
            end
         end
      end
      checks++;
      if (press_cnt_b[0] - snap != 6) begin
         errors++;
         $display("FAIL repeat_count: %0d pulses, required 6", press_cnt_b[0] - snap);
      end
   endtask

   task automatic test_reset_mid_repeat();
      logic e;
      wait_tick();
      raw_b[0] = 1'b1;
      repeat (3) wait_tick();
      repeat (6) wait_tick();
      @(negedge clk_in);
      checks++;
      if ({level_b[0], press_b[0]} !== 2'b11) begin
         errors++;
         $display("FAIL pre_reset: level=%b press=%b required 1 1", level_b[0], press_b[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({level_b, press_b, tick_b, level_a, press_a, tick_a} !== 22'b0) begin
         errors++;
         $display("FAIL async_reset: level_b=%b press_b=%b tick_b=%b required all 0",
                  level_b, press_b, tick_b);
      end
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_tick();
         @(negedge clk_in);
         e = (k == 3);
         checks++;
         if (level_b[0] !== e) begin
            errors++;
            $display("FAIL post_reset tick %0d: level=%b required %b", k, level_b[0], e);
         end
      end
      @(negedge clk_in);
      checks++;
      if (press_b !== 5'b00001) begin
         errors++;
         $display("FAIL post_reset_press: press=%b required 00001", press_b);
      end
      raw_b[0] = 1'b0;
      repeat (4) wait_tick();
   endtask

   task automatic test_two_lanes();
      int           snap [N];
      logic [N-1:0] e;
      logic [N-1:0] got;
      wait_tick();
      for (int i = 0; i < N; i++) snap[i] = press_cnt_a[i];
      raw_a = 5'b01010;
      for (int k = 1; k <= 3; k++) begin
         wait_tick();
         @(negedge clk_in);
         e = (k == 3) ? 5'b01010 : 5'b00000;
         checks++;
         if (level_a !== e) begin
            errors++;
            $display("FAIL two_lanes_level tick %0d: level=%b required %b", k, level_a, e);
         end
      end
      @(negedge clk_in);
      checks++;
      if (press_a !== 5'b01010) begin
         errors++;
         $display("FAIL two_lanes_press: press=%b required 01010", press_a);
      end
      @(negedge clk_in);
      checks++;
      if (press_a !== 5'b00000) begin
         errors++;
         $display("FAIL two_lanes_width: press=%b required 00000", press_a);
      end
      repeat (3) wait_tick();
      for (int i = 0; i < N; i++) got[i] = ((press_cnt_a[i] - snap[i]) == 1);
      checks++;
      if (got !== 5'b01010) begin
         errors++;
         $display("FAIL two_lanes_count: lanes with one pulse=%b required 01010", got);
      end
      raw_a = '0;
      repeat (4) wait_tick();
   endtask

   task automatic test_freeze();
      int ticks_seen;
      slow_run = 1'b0;
      repeat (20) @(negedge clk_in);
      raw_a[2] = 1'b1;
      ticks_seen = 0;
      repeat (200) begin
         @(negedge clk_in);
         if (tick_a === 1'b1) ticks_seen++;
      end
      checks++;
      if (ticks_seen != 0 || level_a[2] !== 1'b0) begin
         errors++;
         $display("FAIL freeze: ticks=%0d level=%b required 0 ticks level 0", ticks_seen, level_a[2]);
      end
      slow_run = 1'b1;
      repeat (3) wait_tick();
      @(negedge clk_in);
      checks++;
      if (level_a[2] !== 1'b1) begin
         errors++;
         $display("FAIL resume: level=%b required 1", level_a[2]);
      end
      raw_a[2] = 1'b0;
      repeat (4) wait_tick();
   endtask

   initial begin
      test_reset();
      test_tick();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_repeat();
      test_reset_mid_repeat();
      test_two_lanes();
      test_freeze();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
